// File: rtl/servo_pwm_multi.sv
// Multi-channel hobby-servo PWM generator sharing one frame counter; new positions take effect only at frame boundaries.
// Optional slew limiting of the per-frame pulse change is enabled by defining SERVO_SLEW_EN.
module servo_pwm_multi #(
    parameter int CHANNELS      = 2,
    parameter int POS_W         = 8,
    parameter int PERIOD_CYCLES = 481000,
    parameter int MIN_PULSE     = 11200,
    parameter int STEP          = 228,
    parameter int MAX_PULSE     = 69500,
    parameter int RESET_POS     = 128,
    parameter int SLEW_STEP     = 1166,
    localparam int CHW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [CHW-1:0]      cmd_ch,
    input  logic [POS_W-1:0]    cmd_pos,
    input  logic                cmd_en,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                frame_start,
    output logic [CHANNELS-1:0] at_target
);

    localparam int CW = $clog2(PERIOD_CYCLES);
    localparam int PW = $clog2(MAX_PULSE + 1);
    localparam int AW = (CW > PW) ? CW : PW;

`ifdef SERVO_SLEW_EN
    localparam int SLEW_LIMIT = SLEW_STEP;
`else
    // A limit at least as wide as the whole pulse range never binds, so active jumps straight to target.
    localparam int SLEW_LIMIT = (SLEW_STEP > MAX_PULSE) ? SLEW_STEP : MAX_PULSE;
`endif

    function automatic logic [PW-1:0] pulse_of(input logic [POS_W-1:0] pos);
        logic [31:0] full;
        full = 32'(MIN_PULSE) + 32'(pos) * 32'(STEP);
        if (full > 32'(MAX_PULSE))
            full = 32'(MAX_PULSE);
        return PW'(full);
    endfunction

    function automatic logic [PW-1:0] step_toward(input logic [PW-1:0] cur, input logic [PW-1:0] tgt);
        logic [31:0] c;
        logic [31:0] t;
        logic [31:0] d;
        c = 32'(cur);
        t = 32'(tgt);
        if (t >= c) begin
            d = t - c;
            if (d > 32'(SLEW_LIMIT))
                d = 32'(SLEW_LIMIT);
            return PW'(c + d);
        end else begin
            d = c - t;
            if (d > 32'(SLEW_LIMIT))
                d = 32'(SLEW_LIMIT);
            return PW'(c - d);
        end
    endfunction

    localparam logic [PW-1:0] RESET_PULSE = pulse_of(POS_W'(RESET_POS));

    logic [CW-1:0]       cnt;
    logic [PW-1:0]       target [CHANNELS];
    logic [PW-1:0]       active [CHANNELS];
    logic [CHANNELS-1:0] en;
    logic [CHANNELS-1:0] en_pending;
    logic                boundary;
    logic                accept;
    logic [PW-1:0]       cmd_target;

    assign boundary   = (cnt == CW'(PERIOD_CYCLES - 1));
    assign cmd_ready  = !boundary;
    assign accept     = cmd_valid && cmd_ready;
    assign cmd_target = pulse_of(cmd_pos);

    // Commands only touch target/en_pending; active and en are copied over solely in the boundary
    // cycle, which refuses commands, so a frame's pulse can never be cut short or stretched.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            frame_start <= 1'b0;
            pwm_out     <= '0;
            en          <= '0;
            en_pending  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                target[i] <= RESET_PULSE;
                active[i] <= RESET_PULSE;
            end
        end else begin
            cnt         <= boundary ? '0 : cnt + CW'(1);
            frame_start <= (cnt == '0);
            for (int i = 0; i < CHANNELS; i++) begin
                pwm_out[i] <= en[i] && (AW'(cnt) < AW'(active[i]));
                if (accept && (cmd_ch == CHW'(i))) begin
                    if (cmd_en)
                        target[i] <= cmd_target;
                    en_pending[i] <= cmd_en;
                end
                if (boundary) begin
                    active[i] <= step_toward(active[i], target[i]);
                    en[i]     <= en_pending[i];
                end
            end
        end
    end

    always_comb begin
        at_target = '0;
        for (int i = 0; i < CHANNELS; i++)
            at_target[i] = (active[i] == target[i]);
    end

endmodule
